// File: rtl/send_cam.sv
// send_cam -- DVP (OV-style) camera transmitter.
//
// Produces a synthetic camera frame on cmos_vsyn / cmos_href / cmos_data,
// clocked by cmos_pclk. Each pixel is sent as two bytes, high byte first.
// Pixels come in through a one-entry holding register with a valid/ready
// handshake.
//
// Handshake: a pixel transfers on every rising edge where
// pix_valid & pix_ready. The source holds pix_data stable while pix_valid=1
// and pix_ready=0. pix_ready does not depend on pix_valid.
//
// Ports
//   cmos_pclk   in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   frame enable, sampled only in IDLE
//   pix_data    in   [15:8] sent first, [7:0] second
//   pix_valid   in   pix_data valid
//   pix_ready   out  holding register can take a pixel this cycle
//   cmos_data   out  registered DVP byte (0x00 while href=0)
//   cmos_href   out  registered line valid
//   cmos_vsyn   out  registered frame sync, active high
//   frame_done  out  one-cycle pulse in the cycle after VFRONT ends
//   underrun    out  sticky: a byte pair was launched with no pixel held
//   fsm_state   out  current FSM state (debug)
module send_cam #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int VS_W     = 8,
  parameter int V_BACK   = 16,
  parameter int H_BLANK  = 144,
  parameter int V_FRONT  = 10
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  cmos_data,
  output logic        cmos_href,
  output logic        cmos_vsyn,
  output logic        frame_done,
  output logic        underrun,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    LINE   = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } state_t;

  // Last count value of each timed state (counters start at 0 on entry).
  localparam logic [11:0] VS_LAST   = 12'(VS_W - 1);
  localparam logic [11:0] VB_LAST   = 12'(V_BACK - 1);
  localparam logic [11:0] LINE_LAST = 12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] HB_LAST   = 12'(H_BLANK - 1);
  localparam logic [11:0] VF_LAST   = 12'(V_FRONT - 1);
  localparam logic [11:0] V_LINES   = 12'(V_ACTIVE);

  state_t      state, state_next;
  logic [11:0] cnt, cnt_next;
  logic [11:0] line_cnt, line_next;
  logic        fd_next;
  logic        take;
  logic        low_next;
  logic        accept;
  logic [15:0] hold;
  logic        hold_full;
  logic [7:0]  lo_byte;

  assign fsm_state = state;

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 12'd1;
    line_next  = line_cnt;
    fd_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = 12'd0;
        if (en) begin
          state_next = VSYNC;
          line_next  = 12'd0;
        end
      end
      VSYNC: begin
        if (cnt == VS_LAST) begin
          state_next = VBACK;
          cnt_next   = 12'd0;
        end
      end
      VBACK: begin
        if (cnt == VB_LAST) begin
          state_next = LINE;
          cnt_next   = 12'd0;
        end
      end
      LINE: begin
        if (cnt == LINE_LAST) begin
          state_next = HBLANK;
          cnt_next   = 12'd0;
          line_next  = line_cnt + 12'd1;
        end
      end
      HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_next   = 12'd0;
          state_next = (line_cnt < V_LINES) ? LINE : VFRONT;
        end
      end
      VFRONT: begin
        if (cnt == VF_LAST) begin
          state_next = IDLE;
          cnt_next   = 12'd0;
          fd_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 12'd0;
      end
    endcase
  end

  // Outputs are loaded from the next-state view so that the registered
  // href/vsyn/data line up exactly with the state they belong to. The cycle
  // that loads a high byte is the take cycle; the one after loads the low byte.
  assign take      = (state_next == LINE) && !cnt_next[0];
  assign low_next  = (state_next == LINE) &&  cnt_next[0];
  assign pix_ready = !hold_full || take;
  assign accept    = pix_valid && pix_ready;

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 12'd0;
      line_cnt   <= 12'd0;
      frame_done <= 1'b0;
      cmos_vsyn  <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= 8'h00;
      underrun   <= 1'b0;
      hold       <= 16'h0000;
      hold_full  <= 1'b0;
      lo_byte    <= 8'h00;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      line_cnt   <= line_next;
      frame_done <= fd_next;
      cmos_vsyn  <= (state_next == VSYNC);
      cmos_href  <= (state_next == LINE);

      if (take) begin
        // An empty hold sends a zero pixel; line timing never stalls.
        cmos_data <= hold_full ? hold[15:8] : 8'h00;
        lo_byte   <= hold_full ? hold[7:0]  : 8'h00;
        if (!hold_full) underrun <= 1'b1;
      end else if (low_next) begin
        cmos_data <= lo_byte;
      end else begin
        cmos_data <= 8'h00;
      end

      // Refill wins over drain so take + accept in one cycle has no bubble.
      if (accept) begin
        hold      <= pix_data;
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: doc/send_cam.md
SEND_CAM -- requirements
Module: send_cam

Interface
REQ-001 Parameter H_ACTIVE, 640, pixels per line; each pixel is 2 href-high cycles.
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter VS_W, 8, cycles cmos_vsyn is held high per frame.
REQ-004 Parameter V_BACK, 16, href-low cycles between vsyn fall and the first line.
REQ-005 Parameter H_BLANK, 144, href-low cycles after every line, including the last.
REQ-006 Parameter V_FRONT, 10, href-low cycles after the last line's H_BLANK.
REQ-007 cmos_pclk  in  1  sole clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 en  in  1  frame enable; sampled only in IDLE.
REQ-010 pix_data  in  16  pixel; [15:8] is sent first, [7:0] second.
REQ-011 pix_valid  in  1  pix_data valid.
REQ-012 pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
REQ-013 cmos_data  out  8  registered DVP byte.
REQ-014 cmos_href  out  1  registered line-valid.
REQ-015 cmos_vsyn  out  1  registered frame sync, active high.
REQ-016 frame_done  out  1  one-cycle pulse at the end of each frame.
REQ-017 underrun  out  1  sticky flag: a pixel was needed and none was held.

Function
REQ-018 The FSM SHALL have the states IDLE, VSYNC, VBACK, LINE, HBLANK and VFRONT; each timing counter is 12 bits and is cleared on every state entry.
REQ-019 Transitions SHALL be: IDLE->VSYNC when en=1; VSYNC->VBACK after VS_W cycles; VBACK->LINE after V_BACK cycles; LINE->HBLANK after 2*H_ACTIVE cycles; HBLANK->LINE if the line count is below V_ACTIVE, else ->VFRONT after H_BLANK cycles; VFRONT->IDLE after V_FRONT cycles.
REQ-020 Outputs SHALL be registered so that cmos_vsyn=1 exactly during VSYNC cycles, cmos_href=1 exactly during LINE cycles, and both are 0 in all other states.
REQ-021 From IDLE with en held at 1, a frame SHALL span VS_W+V_BACK+V_ACTIVE*(2*H_ACTIVE+H_BLANK)+V_FRONT cycles, and the next VSYNC SHALL start one IDLE cycle later.
REQ-022 A one-entry holding register (hold, hold_full) SHALL buffer input pixels; pix_ready = !hold_full | take, where take is 1 on each LINE cycle that launches a high byte.
REQ-023 On a take cycle, cmos_data SHALL load hold[15:8] and an internal low-byte register SHALL load hold[7:0]; on the following LINE cycle, cmos_data SHALL load the low-byte register.
REQ-024 A simultaneous take and accepted input SHALL refill hold in the same cycle, with no bubble.
REQ-025 A take with hold_full=0 SHALL send 0x00 for both bytes of that pixel and set underrun; the line timing SHALL NOT stall.
REQ-026 cmos_data SHALL be 0x00 whenever cmos_href=0.
REQ-027 Deasserting en mid-frame SHALL NOT affect the current frame; the FSM SHALL stop in IDLE after VFRONT.
REQ-028 frame_done SHALL be 1 for the single cycle in which VFRONT exits.
REQ-029 Pixels accepted outside LINE SHALL wait in hold and SHALL NOT be dropped.

Reset
REQ-030 A cycle with rst=1 SHALL force IDLE, clear all counters, set hold_full=0, and make cmos_data=0, cmos_href=0, cmos_vsyn=0, frame_done=0 and underrun=0 on the next edge.
REQ-031 These reset values SHALL hold even when rst is asserted mid-line.
REQ-032 pix_ready SHALL be 1 in the first cycle after reset.
REQ-033 After rst falls, the FSM SHALL remain in IDLE until en=1 is sampled.

Verification
REQ-034 Parameters H_ACTIVE=4, V_ACTIVE=2, VS_W=3, V_BACK=2, H_BLANK=3, V_FRONT=2, en=1 -> vsyn high 3 cycles, two href bursts of 8 cycles separated by 3 low cycles, frame_done 29 cycles after the first vsyn, next vsyn 1 cycle later.
REQ-035 Stream pixels 0x1234, 0x5678, 0xABCD, 0xEF01 with pix_valid always 1 -> line 1 bytes are 12 34 56 78 AB CD EF 01 and underrun stays 0.
REQ-036 pix_valid=0 throughout -> href timing unchanged, all 16 bytes are 0x00, underrun=1 from the first take cycle until reset.
REQ-037 Drop en in the middle of line 1 -> the frame completes, frame_done pulses once, and no further vsyn appears.
REQ-038 Assert rst in the middle of line 2 -> all outputs are 0 on the next edge, and after release a fresh frame starts with vsyn once en=1.
REQ-039 Present one pixel during VBACK and hold pix_valid=0 afterward -> that pixel is the first line byte pair, and underrun sets at the second take.
